rr_arb_4to1: RTL and testbench
==============================

# rr_arb_4to1

Four-requester round-robin arbiter that produces the 2-bit index and enable consumed by the team's 2-to-4 decoder stage. Each cycle it either holds the current grant or selects the next requester in rotating priority. Its registered `sel_out`/`en_out` pair drives the decoder's select/enable inputs directly. It enforces a bounded hold time so that one requester cannot starve the others.

## Interface
- `MAX_HOLD`, default 16. Maximum number of granted cycles before a forced release, applied only when another requester is waiting. Legal range is 2..256. The hold counter width is `$clog2(MAX_HOLD)`.

- `clk_in`  input  1  Single clock. All state changes on the rising edge.
- `rst_n_in`  input  1  Asynchronous active-low reset.
- `req_in`  input  4  Request vector. Bit i is requester i. Level-sensitive.
- `done_in`  input  1  Current grantee releases the grant. Sampled only in GRANT.
- `sel_out`  output  2  Registered index of the granted requester.
- `en_out`  output  1  Registered grant-valid flag.
- `timeout_out`  output  1  One-cycle pulse on a forced release.

## Operation
- Two states, IDLE and GRANT, plus a 2-bit priority pointer `ptr` and a hold counter `hold_cnt`.
- Reset values: state IDLE, `ptr`=0, `hold_cnt`=0, `sel_out`=2'b00, `en_out`=0, `timeout_out`=0.
- IDLE behaviour:
  - If `req_in`==0, remain in IDLE with `en_out`=0. `sel_out` holds its last value.
  - Otherwise the winner w is the first set bit scanning `ptr`, `ptr`+1, … mod 4.
  - At the next edge: `sel_out`<=w, `en_out`<=1, `ptr`<=(w+1) mod 4 (3 wraps to 0), `hold_cnt`<=0, go to GRANT.
- GRANT behaviour, evaluated in priority order each cycle:
  1. Release if `done_in`=1 or `req_in[sel_out]`=0. Next edge: `en_out`<=0, state IDLE, no timeout.
  2. Otherwise, if `hold_cnt`==MAX_HOLD-1 and any other bit of `req_in` is set, force release. Next edge: `en_out`<=0, `timeout_out`<=1, state IDLE.
  3. Otherwise stay in GRANT. `hold_cnt` increments and saturates at MAX_HOLD-1.
- `done_in` and a timeout condition in the same cycle: done wins and `timeout_out` stays 0.
- `done_in` sampled in IDLE is ignored.
- `sel_out` never changes while `en_out`=1.
- `timeout_out` is high for exactly one cycle and clears at the following edge.

## Timing
- Grant latency: a request seen in IDLE on edge N gives `en_out`=1 and a valid `sel_out` after edge N.
- Release latency: a release condition sampled on edge M gives `en_out`=0 after edge M.
- Every release is followed by exactly one dead cycle with `en_out`=0. The next grant appears one edge later, so the minimum gap between grants is 1 cycle.
- Maximum grant length under contention is MAX_HOLD cycles of `en_out`=1.
- Without contention there is no limit: the counter saturates and no timeout fires.
- Reset mid-grant: `en_out`, `timeout_out` and `sel_out` go to 0 immediately, without waiting for a clock edge. The first grant after reset deasserts starts from `ptr`=0.
- Starvation bound: any requester that holds `req_in` high is granted within 3×(MAX_HOLD+1) cycles.

## Test plan
- **Reset.** Hold `rst_n_in`=0 with `req_in`=4'b1111 → `en_out`=0, `sel_out`=0, `timeout_out`=0. Assert reset mid-grant → `en_out` drops before the next clock edge.
- **Single request.** `req_in`=4'b0100 from cycle 1, `done_in` pulsed in cycle 5 → `en_out`=1 and `sel_out`=2 after edge 1. `en_out`=0 after edge 5. Re-grant of `sel_out`=2 after edge 6.
- **Rotation with wrap.** `req_in`=4'b1111 held, `done_in` pulsed on each first granted cycle → `sel_out` sequence 0,1,2,3,0,1, with a one-cycle `en_out`=0 gap between grants.
- **Forced release.** MAX_HOLD=4, `req_in`=4'b0011, `done_in`=0 → `sel_out`=0 for 4 cycles, then `en_out`=0 and `timeout_out`=1 for one cycle, then `sel_out`=1 for 4 cycles.
- **No contention.** MAX_HOLD=4, `req_in`=4'b1000 for 20 cycles, no `done_in` → `en_out`=1 and `sel_out`=3 throughout, `timeout_out` never asserts.
- **Simultaneous events.** MAX_HOLD=4, `req_in`=4'b0110, `done_in`=1 on the 4th granted cycle → release with `timeout_out`=0. Dropping `req_in[sel_out]` mid-grant → release on the next edge.

Source files
------------

// File: rtl/rr_arb_4to1.sv
// Four-requester round-robin arbiter feeding the 2-to-4 decoder select/enable pair.
// A grant is held until done/drop, or force-released after MAX_HOLD cycles under contention.
module rr_arb_4to1 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [3:0] req_in,
    input  logic       done_in,
    output logic [1:0] sel_out,
    output logic       en_out,
    output logic       timeout_out
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [1:0]       r_sel;
    logic             r_en;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic [1:0]       w_sel_nxt;
    logic             w_en_nxt;
    logic             w_timeout_nxt;

    logic [1:0]       w_winner;
    logic             w_found;
    logic [1:0]       w_scan;
    logic [3:0]       w_sel_mask;
    logic             w_other_req;
    logic             w_own_req;

    // Rotating-priority scan starting at the pointer; first set request wins.
    always_comb begin
        w_winner = r_ptr;
        w_found  = 1'b0;
        w_scan   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_scan = r_ptr + k[1:0];
            if (!w_found && req_in[w_scan]) begin
                w_winner = w_scan;
                w_found  = 1'b1;
            end
        end
    end

    assign w_sel_mask  = 4'b0001 << r_sel;
    assign w_other_req = |(req_in & ~w_sel_mask);
    assign w_own_req   = |(req_in & w_sel_mask);

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_sel_nxt      = r_sel;
        w_en_nxt       = r_en;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_en_nxt = 1'b0;
                if (w_found) begin
                    w_sel_nxt      = w_winner;
                    w_en_nxt       = 1'b1;
                    w_ptr_nxt      = w_winner + 2'd1;
                    w_hold_cnt_nxt = '0;
                    w_state_nxt    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A voluntary release outranks the forced one, so done never reports a timeout.
                if (done_in || !w_own_req) begin
                    w_en_nxt    = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if ((r_hold_cnt == HOLD_LAST) && w_other_req) begin
                    w_en_nxt      = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_en_nxt    = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 2'd0;
            r_hold_cnt <= '0;
            r_sel      <= 2'd0;
            r_en       <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_sel      <= w_sel_nxt;
            r_en       <= w_en_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign sel_out     = r_sel;
    assign en_out      = r_en;
    assign timeout_out = r_timeout;

endmodule

// File: tb/tb_rr_arb_4to1.sv
// Scoreboard bench for rr_arb_4to1 (MAX_HOLD=4): directed vectors push expected outputs,
// a negedge monitor pops and compares them against the registered DUT outputs.
module tb_rr_arb_4to1;

    logic       clk_in;
    logic       rst_n_in;
    logic [3:0] req_in;
    logic       done_in;
    logic [1:0] sel_out;
    logic       en_out;
    logic       timeout_out;

    int compareCount = 0;
    int failCount    = 0;

    typedef struct {
        string      tag;
        logic       en;
        logic [1:0] sel;
        logic       to;
    } exp_t;

    exp_t expQ[$];

    rr_arb_4to1 #(.MAX_HOLD(4)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .req_in      (req_in),
        .done_in     (done_in),
        .sel_out     (sel_out),
        .en_out      (en_out),
        .timeout_out (timeout_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic en, input logic [1:0] sel, input logic to);
        compareCount++;
        if ({en_out, sel_out, timeout_out} !== {en, sel, to}) begin
            failCount++;
            $display("[TB] FAIL %s: got en=%b sel=%0d to=%b, expected en=%b sel=%0d to=%b",
                     tag, en_out, sel_out, timeout_out, en, sel, to);
        end
    endtask

    // Inputs are applied for the coming edge; the expectation is the state after that edge.
    task automatic applyStimulus(input string tag, input logic [3:0] req, input logic done,
                                 input logic en, input logic [1:0] sel, input logic to);
        exp_t e;
        req_in  = req;
        done_in = done;
        @(posedge clk_in);
        e.tag = tag;
        e.en  = en;
        e.sel = sel;
        e.to  = to;
        expQ.push_back(e);
        @(negedge clk_in);
    endtask

    always @(negedge clk_in) begin
        if (expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput(e.tag, e.en, e.sel, e.to);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n_in = 1'b0;
        req_in   = 4'b1111;
        done_in  = 1'b0;

        applyStimulus("reset0", 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus("reset1", 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
        rst_n_in = 1'b1;

        // Single request, done on the 5th cycle, then re-grant from ptr=3
        applyStimulus("single_grant", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus("single_hold", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
        applyStimulus("single_done", 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0);
        applyStimulus("single_regrant", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
        applyStimulus("single_drop", 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);
        applyStimulus("idle_hold_sel", 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);

        // Reset to bring ptr back to 0 before the rotation sequence
        rst_n_in = 1'b0;
        applyStimulus("reset2", 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
        rst_n_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus("rotate_grant", 4'b1111, 1'b0, 1'b1, 2'(i % 4), 1'b0);
            applyStimulus("rotate_gap", 4'b1111, 1'b1, 1'b0, 2'(i % 4), 1'b0);
        end

        // Forced release: ptr=2 so requester 0 wins first, then requester 1
        for (int i = 0; i < 4; i++)
            applyStimulus("force_hold0", 4'b0011, 1'b0, 1'b1, 2'd0, 1'b0);
        applyStimulus("force_timeout0", 4'b0011, 1'b0, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++)
            applyStimulus("force_hold1", 4'b0011, 1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus("force_timeout1", 4'b0011, 1'b0, 1'b0, 2'd1, 1'b1);
        applyStimulus("force_clear", 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);

        // No contention: requester 3 keeps the grant indefinitely
        for (int i = 0; i < 20; i++)
            applyStimulus("nocontend", 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
        applyStimulus("nocontend_drop", 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);

        // done on the 4th granted cycle coincides with the timeout condition
        for (int i = 0; i < 4; i++)
            applyStimulus("simul_hold", 4'b0110, 1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus("simul_done_wins", 4'b0110, 1'b1, 1'b0, 2'd1, 1'b0);
        applyStimulus("simul_next", 4'b0110, 1'b0, 1'b1, 2'd2, 1'b0);
        applyStimulus("simul_next_hold", 4'b0110, 1'b0, 1'b1, 2'd2, 1'b0);
        applyStimulus("drop_own_req", 4'b0010, 1'b0, 1'b0, 2'd2, 1'b0);
        applyStimulus("idle_done_noreq", 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0);
        applyStimulus("idle_done_ignored", 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
        applyStimulus("after_idle_done", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus("release_again", 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);

        // Asynchronous reset mid-grant; ptr=3 before reset, must restart from 0
        applyStimulus("pre_reset_grant", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 2'd0, 1'b0);
        applyStimulus("reset_held", 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0);
        rst_n_in = 1'b1;
        applyStimulus("post_reset_ptr0", 4'b1010, 1'b0, 1'b1, 2'd1, 1'b0);

        repeat (2) @(negedge clk_in);
        compareCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
